// File: rtl/fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline latch.
// Owns the PC, issues icache reads and captures returned words for decode.
// It honours stalls, flushes, downstream redirects and HALT.
module fetch_stage #(
    parameter int                 WORD_W  = 32,
    parameter logic [WORD_W-1:0]  PC_INIT = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic [WORD_W-1:0] iload,
    output logic              iREN,
    output logic [WORD_W-1:0] iaddr,
    input  logic              stall,
    input  logic              flush,
    input  logic              redirect_en,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              halt_dec,
    output logic              ifid_valid,
    output logic [WORD_W-1:0] ifid_instr,
    output logic [WORD_W-1:0] ifid_pc,
    output logic [WORD_W-1:0] ifid_pc4,
    output logic              halted
);

    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_plus4;

    // Sequential PC increment; wraps modulo 2^WORD_W.
    assign pc_plus4 = pc + WORD_W'(4);

    // The icache sees the current PC; reads stop once halted or while reset is held.
    assign iaddr = pc;
    assign iREN  = ~halted & ~RST;

    // PC register and halt flag: reset, then redirect, then halt, then advance on an unstalled hit.
    always_ff @(posedge CLK) begin
        // NOTE: reset is synchronous, so RST is sampled only at the clock edge and
        // overrides every other input on that edge.
        if (RST) begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples the pre-edge values, whatever order the statements are written in.
            pc     <= PC_INIT;
            halted <= 1'b0;
        end else if (redirect_en) begin
            // A resolved redirect restarts fetch even from the halted state.
            pc     <= redirect_pc;
            halted <= 1'b0;
        end else begin
            if (halt_dec)
                halted <= 1'b1;
            if (!halted && ihit && !stall)
                pc <= pc_plus4;
        end
    end

    // IF/ID latch: squash on redirect/flush, hold on stall, bubble after HALT or on a miss.
    always_ff @(posedge CLK) begin
        if (RST || redirect_en || flush) begin
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
            ifid_pc    <= '0;
            ifid_pc4   <= '0;
        end else if (stall) begin
            // A word fetched under stall is dropped; the same address is re-read next cycle.
            ifid_valid <= ifid_valid;
            ifid_instr <= ifid_instr;
            ifid_pc    <= ifid_pc;
            ifid_pc4   <= ifid_pc4;
        end else if (halted || halt_dec || !ihit) begin
            // Bubble: an all-zero word is sll $0,$0,0, a harmless nop for decode.
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
            ifid_pc    <= ifid_pc;
            ifid_pc4   <= ifid_pc4;
        end else begin
            ifid_valid <= 1'b1;
            ifid_instr <= iload;
            ifid_pc    <= pc;
            ifid_pc4   <= pc_plus4;
        end
    end

endmodule
